div_seq: RTL



---
 rtl/div_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; EX holds on stall_o until the one-cycle ready_o pulse.
module div_seq #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  annul_i,
   input  logic                  signed_i,
   input  logic                  rem_i,
   input  logic [DATA_WIDTH-1:0] opdata1_i,
   input  logic [DATA_WIDTH-1:0] opdata2_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  ready_o,
   output logic                  stall_o
);

   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, ZERO, DIVIDE, DONE} state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] dvd_q;     // original dividend, needed for REM by zero
   logic [DATA_WIDTH-1:0] dvsr_q;
   logic [DATA_WIDTH-1:0] rem_q;
   logic [DATA_WIDTH-1:0] quo_q;     // dividend bits shift out the top, quotient bits in the bottom
   logic [DATA_WIDTH-1:0] res_q;
   logic [CW-1:0]         cnt;
   logic                  rem_sel;
   logic                  neg_q;
   logic                  neg_r;

   logic                  a_neg, b_neg, accept, last;
   logic [DATA_WIDTH-1:0] a_mag, b_mag;
   logic [DATA_WIDTH:0]   part, diff;
   logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;

   assign a_neg  = signed_i & opdata1_i[DATA_WIDTH-1];
   assign b_neg  = signed_i & opdata2_i[DATA_WIDTH-1];
   assign a_mag  = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
   assign b_mag  = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
   assign accept = (state == IDLE) && start_i && !annul_i;
   assign last   = (cnt == CW'(DATA_WIDTH-1));

   // Trial subtraction; partial remainder is always < 2*divisor so 33 bits suffice.
   assign part    = {rem_q, quo_q[DATA_WIDTH-1]};
   assign diff    = part - {1'b0, dvsr_q};
   assign rem_nxt = diff[DATA_WIDTH] ? part[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
   assign quo_nxt = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      result_o  = '0;
      stall_o   = 1'b0;
      case (state)
         IDLE: begin
            stall_o = accept;
            if (accept) state_nxt = (opdata2_i == '0) ? ZERO : DIVIDE;
         end
         ZERO: begin
            stall_o   = 1'b1;
            state_nxt = DONE;
         end
         DIVIDE: begin
            stall_o = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            ready_o   = !annul_i;
            result_o  = annul_i ? '0 : res_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (annul_i) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q   <= '0;
         dvsr_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
         cnt     <= '0;
         rem_sel <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               dvd_q   <= opdata1_i;
               dvsr_q  <= b_mag;
               quo_q   <= a_mag;
               rem_q   <= '0;
               cnt     <= '0;
               rem_sel <= rem_i;
               neg_q   <= a_neg ^ b_neg;
               neg_r   <= a_neg;
            end
            ZERO: res_q <= rem_sel ? dvd_q : '1;
            DIVIDE: begin
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               cnt   <= cnt + 1'b1;
               if (last)
                  res_q <= rem_sel ? (neg_r ? (~rem_nxt + 1'b1) : rem_nxt)
                                   : (neg_q ? (~quo_nxt + 1'b1) : quo_nxt);
            end
            default: ;
         endcase
      end
   end

endmodule
